// File: rtl/main_memory.sv
// Word-organised processor memory with a boot loader that streams a program
// image from a host into word 0 upward, holding the processor in reset until done.
//
// state  | meaning
// BOOT   | cpuReset high, host words written at ptr, processor bus ignored
// SETTLE | one extra cycle of cpuReset after the final image word
// RUN    | processor owns the bus, loader ignored, counters frozen
module main_memory #(
  parameter int ADDR_BITS  = 11,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [15:0]           busA,
  input  logic [DATA_WIDTH-1:0] busB,
  input  logic                  rw,
  output logic [DATA_WIDTH-1:0] dataIn,
  output logic                  cpuReset,
  input  logic                  loadValid,
  input  logic [DATA_WIDTH-1:0] loadData,
  input  logic                  loadLast,
  output logic [ADDR_BITS:0]    loadCount,
  output logic                  loadOverflow
);

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam logic [ADDR_BITS-1:0] PTR_MAX = '1;
  localparam logic [ADDR_BITS-1:0] PTR_ONE = 1;
  localparam logic [ADDR_BITS:0]   CNT_MAX = {1'b1, {ADDR_BITS{1'b0}}};
  localparam logic [ADDR_BITS:0]   CNT_ONE = 1;

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RUN    = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [ADDR_BITS-1:0]   ptr_q, ptr_d;
  logic [ADDR_BITS:0]     load_count_q, load_count_d;
  logic                   overflow_q, overflow_d;
  logic [DATA_WIDTH-1:0]  data_in_q, data_in_d;
  logic                   cpu_reset_q, cpu_reset_d;

  logic [DATA_WIDTH-1:0]  mem [DEPTH];
  logic                   mem_we;
  logic [ADDR_BITS-1:0]   mem_waddr;
  logic [DATA_WIDTH-1:0]  mem_wdata;
  logic [ADDR_BITS-1:0]   cpu_idx;

  // Byte address to word index; the byte-select bit and high bits alias.
  assign cpu_idx = busA[ADDR_BITS:1];

  logic unused_bus_bits;
  assign unused_bus_bits = ^{busA[15:ADDR_BITS+1], busA[0]};

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    load_count_d = load_count_q;
    overflow_d   = overflow_q;
    data_in_d    = data_in_q;
    mem_we       = 1'b0;
    mem_waddr    = ptr_q;
    mem_wdata    = loadData;

    case (state_q)
      ST_BOOT: begin
        data_in_d = '0;
        if (loadValid) begin
          mem_we = 1'b1;
          ptr_d  = ptr_q + PTR_ONE;
          if (ptr_q == PTR_MAX) overflow_d = 1'b1;
          if (load_count_q != CNT_MAX) load_count_d = load_count_q + CNT_ONE;
          if (loadLast) state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (rw) begin
          mem_we    = 1'b1;
          mem_waddr = cpu_idx;
          mem_wdata = busB;
          data_in_d = busB;
        end else begin
          data_in_d = mem[cpu_idx];
        end
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase

    // A store presented alongside reset must not land in memory.
    if (reset) mem_we = 1'b0;

    cpu_reset_d = (state_d != ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_BOOT;
      ptr_q        <= '0;
      load_count_q <= '0;
      overflow_q   <= 1'b0;
      data_in_q    <= '0;
      cpu_reset_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      load_count_q <= load_count_d;
      overflow_q   <= overflow_d;
      data_in_q    <= data_in_d;
      cpu_reset_q  <= cpu_reset_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign dataIn       = data_in_q;
  assign cpuReset     = cpu_reset_q;
  assign loadCount    = load_count_q;
  assign loadOverflow = overflow_q;

endmodule

// File: tb/tb_main_memory.sv
// Scoreboard bench for main_memory: a default-depth instance and a 4-word
// instance exercise boot load, bus reads/writes, aliasing, overflow and reset.
module tb_main_memory;

  localparam int K_DATA   = 0;
  localparam int K_CPURST = 1;
  localparam int K_CNT    = 2;
  localparam int K_OVF    = 3;
  localparam int K_SDATA  = 4;
  localparam int K_SCNT   = 5;
  localparam int K_SOVF   = 6;
  localparam int K_SCPU   = 7;

  logic        clk;
  logic        reset, rw, loadValid, loadLast, cpuReset, loadOverflow;
  logic [15:0] busA, busB, loadData, dataIn;
  logic [11:0] loadCount;

  logic        s_reset, s_rw, s_loadValid, s_loadLast, s_cpuReset, s_loadOverflow;
  logic [15:0] s_busA, s_busB, s_loadData, s_dataIn;
  logic [2:0]  s_loadCount;

  main_memory #(.ADDR_BITS(11), .DATA_WIDTH(16)) u_dut (
    .clk(clk), .reset(reset), .busA(busA), .busB(busB), .rw(rw),
    .dataIn(dataIn), .cpuReset(cpuReset), .loadValid(loadValid),
    .loadData(loadData), .loadLast(loadLast), .loadCount(loadCount),
    .loadOverflow(loadOverflow)
  );

  main_memory #(.ADDR_BITS(2), .DATA_WIDTH(16)) u_small (
    .clk(clk), .reset(s_reset), .busA(s_busA), .busB(s_busB), .rw(s_rw),
    .dataIn(s_dataIn), .cpuReset(s_cpuReset), .loadValid(s_loadValid),
    .loadData(s_loadData), .loadLast(s_loadLast), .loadCount(s_loadCount),
    .loadOverflow(s_loadOverflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          due;
    int          kind;
    logic [15:0] exp;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  function automatic logic [15:0] actual(input int kind);
    case (kind)
      K_DATA:   return dataIn;
      K_CPURST: return {15'b0, cpuReset};
      K_CNT:    return {4'b0, loadCount};
      K_OVF:    return {15'b0, loadOverflow};
      K_SDATA:  return s_dataIn;
      K_SCNT:   return {13'b0, s_loadCount};
      K_SOVF:   return {15'b0, s_loadOverflow};
      default:  return {15'b0, s_cpuReset};
    endcase
  endfunction

  // Expected value of an output as seen just after the next rising edge.
  task automatic expect_out(input int kind, input logic [15:0] exp, input string name);
    exp_t e;
    e.due  = cyc + 1;
    e.kind = kind;
    e.exp  = exp;
    e.name = name;
    sb_q.push_back(e);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      #1;
      while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
        exp_t e;
        logic [15:0] got;
        e   = sb_q.pop_front();
        got = actual(e.kind);
        checks = checks + 1;
        if (e.due != cyc) begin
          errors = errors + 1;
          $display("FAIL %s: check due at cycle %0d ran at cycle %0d", e.name, e.due, cyc);
        end else if (got !== e.exp) begin
          errors = errors + 1;
          $display("FAIL %s: got %h expected %h (cycle %0d)", e.name, got, e.exp, cyc);
        end
      end
    end
  end

  task automatic cpu_op(input logic w, input logic [15:0] addr, input logic [15:0] data,
                        input logic [15:0] exp, input string name);
    rw   = w;
    busA = addr;
    busB = data;
    expect_out(K_DATA, exp, name);
    tick();
  endtask

  task automatic load_word(input logic [15:0] data, input logic last,
                           input logic [15:0] exp_cnt, input string name);
    loadValid = 1'b1;
    loadData  = data;
    loadLast  = last;
    expect_out(K_CNT, exp_cnt, name);
    tick();
    loadValid = 1'b0;
    loadLast  = 1'b0;
  endtask

  task automatic s_op(input logic [15:0] addr, input logic [15:0] exp, input string name);
    s_rw   = 1'b0;
    s_busA = addr;
    expect_out(K_SDATA, exp, name);
    tick();
  endtask

  initial begin
    reset = 1'b1; rw = 1'b0; busA = '0; busB = '0;
    loadValid = 1'b0; loadData = '0; loadLast = 1'b0;
    s_reset = 1'b1; s_rw = 1'b0; s_busA = '0; s_busB = '0;
    s_loadValid = 1'b0; s_loadData = '0; s_loadLast = 1'b0;

    expect_out(K_CPURST, 16'd1, "rst_cpureset");
    expect_out(K_CNT,    16'd0, "rst_count");
    expect_out(K_OVF,    16'd0, "rst_overflow");
    expect_out(K_DATA,   16'h0, "rst_datain");
    tick();
    reset = 1'b0;

    loadLast = 1'b1;
    expect_out(K_CNT,    16'd0, "last_without_valid_count");
    expect_out(K_CPURST, 16'd1, "last_without_valid_cpureset");
    tick();
    loadLast = 1'b0;

    load_word(16'h5140, 1'b0, 16'd1, "boot_count1");
    expect_out(K_CPURST, 16'd1, "settle_cpureset");
    load_word(16'h5A01, 1'b1, 16'd2, "boot_count2");
    expect_out(K_CPURST, 16'd0, "run_cpureset");
    expect_out(K_CNT,    16'd2, "settle_count");
    tick();

    cpu_op(1'b0, 16'h0002, 16'h0000, 16'h5A01, "read_word1");
    cpu_op(1'b0, 16'h0003, 16'h0000, 16'h5A01, "read_bit0_ignored");
    cpu_op(1'b0, 16'h0000, 16'h0000, 16'h5140, "read_word0");
    cpu_op(1'b1, 16'h0800, 16'h0040, 16'h0040, "write_through");
    cpu_op(1'b0, 16'h0800, 16'h0000, 16'h0040, "readback_0800");
    cpu_op(1'b0, 16'h1800, 16'h0000, 16'h0040, "alias_1800");
    cpu_op(1'b0, 16'h0801, 16'h0000, 16'h0040, "alias_0801");
    cpu_op(1'b1, 16'h0020, 16'h1234, 16'h1234, "b2b_write");
    cpu_op(1'b0, 16'h0002, 16'h0000, 16'h5A01, "b2b_read_other");
    cpu_op(1'b0, 16'h0020, 16'h0000, 16'h1234, "b2b_readback");
    cpu_op(1'b1, 16'h0004, 16'hABCD, 16'hABCD, "write_word2");

    loadValid = 1'b1; loadData = 16'hFFFF; loadLast = 1'b1;
    rw = 1'b0; busA = 16'h0004;
    expect_out(K_DATA,   16'hABCD, "run_loader_ignored_data");
    expect_out(K_CNT,    16'd2,    "run_loader_count_frozen");
    expect_out(K_CPURST, 16'd0,    "run_loader_cpureset");
    tick();
    loadValid = 1'b0; loadLast = 1'b0;
    cpu_op(1'b0, 16'h0004, 16'h0000, 16'hABCD, "word2_kept");

    reset = 1'b1; rw = 1'b1; busA = 16'h0800; busB = 16'hDEAD;
    expect_out(K_CPURST, 16'd1, "run_reset_cpureset");
    expect_out(K_CNT,    16'd0, "run_reset_count");
    expect_out(K_DATA,   16'h0, "run_reset_datain");
    tick();
    reset = 1'b0; rw = 1'b0; busA = '0; busB = '0;

    load_word(16'h1111, 1'b0, 16'd1, "reload_count1");
    load_word(16'h2222, 1'b0, 16'd2, "reload_count2");
    load_word(16'h3333, 1'b0, 16'd3, "reload_count3");
    reset = 1'b1; loadValid = 1'b1; loadData = 16'h9999;
    expect_out(K_CNT,    16'd0, "midload_reset_count");
    expect_out(K_CPURST, 16'd1, "midload_reset_cpureset");
    tick();
    reset = 1'b0; loadValid = 1'b0;
    load_word(16'h7777, 1'b1, 16'd1, "second_image_count");
    expect_out(K_CPURST, 16'd0, "second_image_run");
    expect_out(K_OVF,    16'd0, "no_overflow_main");
    tick();
    cpu_op(1'b0, 16'h0000, 16'h0000, 16'h7777, "reload_word0");
    cpu_op(1'b0, 16'h0002, 16'h0000, 16'h2222, "retained_word1");
    cpu_op(1'b0, 16'h0004, 16'h0000, 16'h3333, "retained_word2");
    cpu_op(1'b0, 16'h0800, 16'h0000, 16'h0040, "reset_write_discarded");

    // Small instance: five words into a four-word memory.
    expect_out(K_SCNT, 16'd0, "small_rst_count");
    expect_out(K_SCPU, 16'd1, "small_rst_cpureset");
    tick();
    s_reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      s_loadValid = 1'b1;
      s_loadData  = 16'hA000 + 16'(i);
      s_loadLast  = (i == 4);
      expect_out(K_SCNT, (i < 4) ? 16'(i + 1) : 16'd4, "small_count");
      expect_out(K_SOVF, (i >= 3) ? 16'd1 : 16'd0, "small_overflow");
      expect_out(K_SCPU, 16'd1, "small_boot_cpureset");
      tick();
    end
    s_loadValid = 1'b0; s_loadLast = 1'b0;
    expect_out(K_SCPU, 16'd0, "small_run_cpureset");
    expect_out(K_SCNT, 16'd4, "small_count_saturated");
    tick();
    s_op(16'h0000, 16'hA004, "small_word0_fifth");
    s_op(16'h0002, 16'hA001, "small_word1");
    s_op(16'h0006, 16'hA003, "small_word3");
    s_op(16'h0008, 16'hA004, "small_alias_high");

    tick();
    tick();
    if (sb_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
